// File: rtl/bram_beamformer_sequencer.sv
// Delay-and-sum beamformer sequencer: walks output samples, issues delayed
// per-channel BRAM reads, accumulates and writes the averaged beam sample.
module bram_beamformer_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 12,
  parameter int NUM_SAMPLES = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ADDR_W-1:0] cfg_delay,
  output logic              rd_en,
  output logic [CH_W-1:0]   rd_ch,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int ACC_W = DATA_W + CH_W;
  localparam logic [ADDR_W:0] LAST_S = (ADDR_W+1)'(NUM_SAMPLES - 1);
  localparam logic [CH_W-1:0] LAST_C = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_s;
  logic [CH_W-1:0]   r_c;
  logic [ACC_W-1:0]  r_acc;
  logic              r_cap;
  logic [ADDR_W-1:0] r_dly [NUM_CH];

  logic [ADDR_W-1:0] w_dly;
  logic              w_hit;
  logic              w_last_s;

  assign w_dly    = r_dly[r_c];
  assign w_hit    = (r_s >= w_dly);
  assign w_last_s = ({1'b0, r_s} == LAST_S);

  always_comb begin
    w_next  = r_state;
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    rd_ch   = '0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_READ;
      end
      S_READ: begin
        busy = 1'b1;
        // a channel whose delay exceeds s still burns its slot
        if (w_hit) begin
          rd_en   = 1'b1;
          rd_ch   = r_c;
          rd_addr = r_s - w_dly;
        end
        if (r_c == LAST_C) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy   = 1'b1;
        w_next = S_WRITE;
      end
      S_WRITE: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = r_s;
        wr_data = r_acc[ACC_W-1:CH_W];
        w_next  = w_last_s ? S_DONE : S_READ;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_s     <= '0;
      r_c     <= '0;
      r_acc   <= '0;
      r_cap   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_dly[i] <= '0;
    end else begin
      r_state <= w_next;
      r_cap   <= rd_en;
      if (r_cap) r_acc <= r_acc + {{CH_W{1'b0}}, rd_data};
      if (r_state == S_IDLE) begin
        if (cfg_we) r_dly[cfg_ch] <= cfg_delay;
        if (start) begin
          r_s   <= '0;
          r_c   <= '0;
          r_acc <= '0;
        end
      end
      if (r_state == S_READ) r_c <= r_c + 1'b1;
      if (r_state == S_WRITE) begin
        r_acc <= '0;
        r_s   <= r_s + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bram_beamformer_sequencer.sv
// Scoreboard bench for the beamformer sequencer with a 1-cycle BRAM model.
// Expected beam samples are queued at start and popped on each write.
module tb_bram_beamformer_sequencer;

  localparam int NCH = 4;
  localparam int CW  = 2;
  localparam int AW  = 11;
  localparam int DW  = 12;
  localparam int NS  = 8;
  localparam int PER = NCH + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          cfg_we;
  logic [CW-1:0] cfg_ch;
  logic [AW-1:0] cfg_delay;
  logic          rd_en;
  logic [CW-1:0] rd_ch;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int n_chk  = 0;
  int n_pass = 0;
  int ws     = 0;
  int mode   = 0;
  logic [DW-1:0] cval = '0;
  int dly [NCH];
  logic [AW+DW-1:0] q [$];

  bram_beamformer_sequencer #(
    .NUM_CH(NCH), .CH_W(CW), .ADDR_W(AW),
    .DATA_W(DW), .NUM_SAMPLES(NS)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_delay(cfg_delay),
    .rd_en(rd_en), .rd_ch(rd_ch),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
  endtask

  function automatic int sval(input int a);
    return (mode == 1) ? (a & 'hFFF) : int'(cval);
  endfunction

  task automatic push_model();
    for (int s = 0; s < NS; s++) begin
      int sum;
      sum = 0;
      for (int c = 0; c < NCH; c++)
        if (s >= dly[c]) sum += sval(s - dly[c]);
      q.push_back({AW'(s), DW'(sum / NCH)});
    end
  endtask

  // garbage when not enabled so stray captures show up
  always @(posedge clk)
    rd_data <= rd_en ? DW'(sval(int'(rd_addr))) : 12'hABC;

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en)
        check("rd_addr", 32'(rd_addr), 32'(ws - dly[rd_ch]));
      if (wr_en) begin
        if (q.size() == 0) check("wr_extra", 1, 0);
        else begin
          logic [AW+DW-1:0] e;
          e = q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e[AW+DW-1:DW]));
          check("wr_data", 32'(wr_data), 32'(e[DW-1:0]));
        end
        ws++;
      end
    end
  end

  task automatic cfg(input int c, input int d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_ch    = CW'(c);
    cfg_delay = AW'(d);
    dly[c]    = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run(input int cc, input int cd, input bit poke);
    int k, done_k, busy_n, first_rd, idle_n;
    k = 0; done_k = 0; busy_n = 0; first_rd = 0; idle_n = 0;
    @(negedge clk);
    ws    = 0;
    start = 1'b1;
    if (cc >= 0) begin
      cfg_we    = 1'b1;
      cfg_ch    = CW'(cc);
      cfg_delay = AW'(cd);
      dly[cc]   = cd;
    end
    push_model();
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (k == 1) first_rd = int'(rd_en);
      start  = 1'b0;
      cfg_we = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_k = k;
        break;
      end
      if (poke && k == 10) begin
        start     = 1'b1;
        cfg_we    = 1'b1;
        cfg_ch    = 2'd1;
        cfg_delay = 11'd7;
      end
    end
    check("done_at", done_k, 1 + NS * PER);
    check("busy_cyc", busy_n, NS * PER);
    check("first_rd", first_rd, (dly[0] == 0) ? 1 : 0);
    check("q_empty", q.size(), 0);
    repeat (10) begin
      @(negedge clk);
      if (busy || done) idle_n++;
    end
    check("idle_after", idle_n, 0);
  endtask

  task automatic abort_run();
    int k, bad;
    k = 0; bad = 0;
    @(negedge clk);
    ws    = 0;
    start = 1'b1;
    push_model();
    while (k < 21) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (k == 20) rst = 1'b1;
    end
    check("abort_rd", rd_en, 0);
    check("abort_wr", wr_en, 0);
    check("abort_busy", busy, 0);
    rst = 1'b0;
    q.delete();
    for (int c = 0; c < NCH; c++) dly[c] = 0;
    repeat (60) begin
      @(negedge clk);
      if (done || wr_en || busy) bad++;
    end
    check("abort_quiet", bad, 0);
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) dly[c] = 0;
    rst = 1'b1; start = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_delay = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    rst = 1'b0;

    mode = 0; cval = 12'h100;
    run(-1, 0, 1'b0);

    cfg(1, 1); cfg(2, 2); cfg(3, 3);
    cval = 12'h400;
    run(-1, 0, 1'b0);

    mode = 1;
    cfg(1, 2); cfg(2, 0); cfg(3, 2);
    run(-1, 0, 1'b0);

    run(1, 5, 1'b1);
    run(-1, 0, 1'b0);

    abort_run();
    run(-1, 0, 1'b0);

    mode = 0; cval = 12'hFFF;
    run(-1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
